// File: rtl/led_fader_pkg.sv
// Shared types and defaults for the LED brightness fader.
package led_fader_pkg;

  typedef enum logic [1:0] {ST_OFF, ST_UP, ST_ON, ST_DOWN} chan_state_t;

  localparam int PWM_BITS_DEF = 8;
  localparam int STEP_DIV_DEF = 50000;

  function automatic int max_level(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/led_fader_channel.sv
// One fader channel: ramps level toward the target goal and emits its PWM bit.
module led_fader_channel
  import led_fader_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                gclk,
  input  logic                grst,
  input  logic                target,
  input  logic                fade_en,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic [PWM_BITS-1:0] level,
  output chan_state_t         state,
  output logic                pwm,
  output logic                at_goal
);

  localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(max_level(PWM_BITS));

  logic [PWM_BITS-1:0] goal;
  logic [PWM_BITS-1:0] level_nxt;

  assign goal    = target ? MAX : '0;
  assign at_goal = (level == goal);

  function automatic chan_state_t classify(input logic [PWM_BITS-1:0] lvl, input logic tgt);
    if (tgt) return (lvl == MAX) ? ST_ON : ST_UP;
    else     return (lvl == '0)  ? ST_OFF : ST_DOWN;
  endfunction

  // Stepping always starts from the current level, so a reversal never jumps.
  always_comb begin
    level_nxt = level;
    if (!fade_en)
      level_nxt = goal;
    else if (tick) begin
      if (target && level != MAX)
        level_nxt = level + 1'b1;
      else if (!target && level != '0)
        level_nxt = level - 1'b1;
    end
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      level <= '0;
      state <= ST_OFF;
      pwm   <= 1'b0;
    end else begin
      level <= level_nxt;
      state <= classify(level_nxt, target);
      pwm   <= (level > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_fader.sv
// Per-LED fader/PWM driver behind the PIO LED export; shared step and PWM counters.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int N_LEDS   = 10,
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int STEP_DIV = STEP_DIV_DEF
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [N_LEDS-1:0] leds_in,
  input  logic              fade_en,
  output logic [N_LEDS-1:0] leds_pwm,
  output logic              busy
);

  localparam int                  TW  = $clog2(STEP_DIV);
  localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(max_level(PWM_BITS));

  logic [TW-1:0]                    tick_cnt;
  logic                             tick;
  logic [PWM_BITS-1:0]              pwm_cnt;
  logic [N_LEDS-1:0]                target;
  logic [N_LEDS-1:0]                at_goal;
  logic [N_LEDS-1:0][PWM_BITS-1:0]  level;
  chan_state_t [N_LEDS-1:0]         state;
  logic                             unused_dbg;

  assign tick       = (tick_cnt == TW'(STEP_DIV - 1));
  assign unused_dbg = ^{level, state};

  // PWM period is MAX cycles so that level MAX is a constant high.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      tick_cnt <= '0;
      pwm_cnt  <= '0;
      target   <= '0;
      busy     <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      pwm_cnt  <= (pwm_cnt == MAX - 1'b1) ? '0 : pwm_cnt + 1'b1;
      target   <= leds_in;
      busy     <= ~&at_goal;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    led_fader_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .gclk    (clk_clk),
      .grst    (reset_reset),
      .target  (target[i]),
      .fade_en (fade_en),
      .tick    (tick),
      .pwm_cnt (pwm_cnt),
      .level   (level[i]),
      .state   (state[i]),
      .pwm     (leds_pwm[i]),
      .at_goal (at_goal[i])
    );
  end

endmodule
